// File: rtl/lzc_stream.sv
// Streaming leading-zero / leading-one / trailing-zero counter over multi-word frames.
// Optional macro LZC_TRAIL_EN compiles in the trailing-zero mode (mode 10).
module lzc_stream #(
  parameter  int WIDTH = 8,
  parameter  int WORD  = 4,
  localparam int CW    = $clog2(WIDTH*WORD) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             Ivalid,
  input  logic             Ilast,
  input  logic [1:0]       mode,
  output logic [CW-1:0]    zeros,
  output logic             Oall,
  output logic             Ovalid
);

  localparam int LW  = $clog2(WIDTH) + 1;
  localparam int WCW = (WORD > 1) ? $clog2(WORD) : 1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     mode_reg;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           found_reg, found_next;
  logic [WCW-1:0] wcnt_reg;

  logic           first;
  logic [1:0]     mode_cur;
  logic           ones;
  logic [WIDTH-1:0] lvec;
  logic           full;
  logic [LW-1:0]  lead;
  logic [CW-1:0]  base_cnt;
  logic           base_found;
  logic [WCW-1:0] wcnt_eff;
  logic           close;
  logic [CW-1:0]  zeros_next;
  logic           oall_next, ovalid_next;

  // The first word of a frame uses the live mode; later words use the latched one.
  assign first    = (state_reg == IDLE);
  assign mode_cur = first ? mode : mode_reg;
  assign ones     = (mode_cur == 2'b01);
  assign lvec     = ones ? ~data : data;

  always_comb begin
    lead = LW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (lvec[i]) lead = LW'(WIDTH - 1 - i);
    end
  end

`ifdef LZC_TRAIL_EN
  logic          trail;
  logic [LW-1:0] tz;

  assign trail = (mode_cur == 2'b10);
  assign full  = trail ? (data == '0) : (lvec == '0);

  always_comb begin
    tz = LW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data[i]) tz = LW'(i);
    end
  end
`else
  assign full = (lvec == '0);
`endif

  assign base_cnt   = first ? '0 : cnt_reg;
  assign base_found = first ? 1'b0 : found_reg;
  assign wcnt_eff   = first ? '0 : wcnt_reg;
  assign close      = Ivalid & (Ilast | (wcnt_eff == WCW'(WORD - 1)));

  always_comb begin
    cnt_next   = base_cnt;
    found_next = base_found | ~full;
`ifdef LZC_TRAIL_EN
    if (trail) begin
      cnt_next = full ? base_cnt + CW'(WIDTH) : CW'(tz);
    end else
`endif
    if (!base_found) begin
      cnt_next = full ? base_cnt + CW'(WIDTH) : base_cnt + CW'(lead);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (Ivalid) state_next = close ? IDLE : ACC;
  end

  always_comb begin
    zeros_next  = zeros;
    oall_next   = Oall;
    ovalid_next = 1'b0;
    if (close) begin
      zeros_next  = cnt_next;
      oall_next   = ~found_next;
      ovalid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      found_reg <= 1'b0;
      wcnt_reg  <= '0;
      mode_reg  <= 2'b00;
    end else if (Ivalid) begin
      cnt_reg   <= cnt_next;
      found_reg <= found_next;
      wcnt_reg  <= wcnt_eff + WCW'(1);
      mode_reg  <= mode_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zeros  <= '0;
      Oall   <= 1'b0;
      Ovalid <= 1'b0;
    end else begin
      zeros  <= zeros_next;
      Oall   <= oall_next;
      Ovalid <= ovalid_next;
    end
  end

endmodule

// File: tb/tb_lzc_stream.sv
// Frame-table driven bench for lzc_stream with a scoreboard of expected frame results.
module tb_lzc_stream;

  localparam int WIDTH = 8;
  localparam int WORD  = 4;
  localparam int CW    = $clog2(WIDTH*WORD) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data = '0;
  logic             Ivalid = 1'b0;
  logic             Ilast = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CW-1:0]    zeros;
  logic             Oall;
  logic             Ovalid;

  lzc_stream #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .data(data), .Ivalid(Ivalid), .Ilast(Ilast),
    .mode(mode), .zeros(zeros), .Oall(Oall), .Ovalid(Ovalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      m;
    int              n;
    logic [3:0][7:0] w;
    logic [3:0]      l;
    int              pg;
    int              ig;
    int              ez;
    bit              ea;
  } frame_t;

  typedef struct {
    int ez;
    bit ea;
    int due;
  } exp_t;

  frame_t frames[$];
  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;
  int     hold_z = 0;
  bit     hold_a = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse is matched against the oldest pending frame; between pulses outputs must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Ovalid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_ovalid got Ovalid=1 zeros=%0d want no pulse", zeros);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("[TB] cycle %0d frame out zeros=%0d Oall=%0d (want %0d/%0d)", cyc, zeros, Oall, e.ez, e.ea);
          tests++;
          if (int'(zeros) != e.ez) begin
            fails++; $display("FAIL frame_zeros got %0d want %0d", zeros, e.ez);
          end
          tests++;
          if (Oall !== e.ea) begin
            fails++; $display("FAIL frame_oall got %0d want %0d", Oall, e.ea);
          end
          tests++;
          if (cyc != e.due) begin
            fails++; $display("FAIL frame_latency got cycle %0d want cycle %0d", cyc, e.due);
          end
          hold_z = e.ez;
          hold_a = e.ea;
        end
      end else begin
        tests++;
        if (int'(zeros) != hold_z || Oall !== hold_a) begin
          fails++;
          $display("FAIL output_hold got zeros=%0d Oall=%0d want zeros=%0d Oall=%0d", zeros, Oall, hold_z, hold_a);
        end
      end
    end
  end

  task automatic send(input logic v, input logic l, input logic [1:0] m, input logic [7:0] d);
    @(posedge clk); #1;
    Ivalid = v; Ilast = l; mode = m; data = d;
  endtask

  task automatic idle();
    send(1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic add(input logic [1:0] m, input int n,
                     input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3,
                     input logic [3:0] l, input int pg, input int ig, input int ez, input bit ea);
    frame_t f;
    f.m = m; f.n = n; f.l = l; f.pg = pg; f.ig = ig; f.ez = ez; f.ea = ea;
    f.w[0] = w0; f.w[1] = w1; f.w[2] = w2; f.w[3] = w3;
    frames.push_back(f);
  endtask

  // Later words carry a different mode so the latch on the first word is exercised.
  task automatic run_frame(input frame_t f);
    exp_t e;
    repeat (f.pg) idle();
    for (int i = 0; i < f.n; i++) begin
      if (i > 0) repeat (f.ig) idle();
      send(1'b1, f.l[i], (i == 0) ? f.m : (f.m ^ 2'b01), f.w[i]);
      if (i == f.n - 1) begin
        e.ez = f.ez; e.ea = f.ea; e.due = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  // A word with Ilast is offered during reset; it must be dropped.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; Ivalid = 1'b1; Ilast = 1'b1; mode = 2'b00; data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0; Ivalid = 1'b0; Ilast = 1'b0;
    hold_z = 0; hold_a = 1'b0;
    sb.delete();
    mon_en = 1'b1;
    @(negedge clk);
    tests++;
    if (zeros !== '0 || Oall !== 1'b0 || Ovalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got zeros=%0d Oall=%0d Ovalid=%0d want 0/0/0", zeros, Oall, Ovalid);
    end
  endtask

  initial begin
    add(2'b00, 4, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 0, 32, 1'b1);
    add(2'b00, 4, 8'h00, 8'h10, 8'h3F, 8'hFF, 4'b0000, 0, 0, 11, 1'b0);
    add(2'b00, 1, 8'h3F, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0,  2, 1'b0);
    add(2'b01, 2, 8'hFF, 8'hF0, 8'h00, 8'h00, 4'b0010, 2, 3, 12, 1'b0);
`ifdef LZC_TRAIL_EN
    add(2'b10, 2, 8'h10, 8'h00, 8'h00, 8'h00, 4'b0010, 0, 0, 12, 1'b0);
    add(2'b10, 3, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0100, 1, 0, 16, 1'b0);
`else
    add(2'b10, 2, 8'h10, 8'h00, 8'h00, 8'h00, 4'b0010, 0, 0,  3, 1'b0);
    add(2'b10, 3, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0100, 1, 0,  7, 1'b0);
`endif
    add(2'b10, 2, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010, 0, 1, 16, 1'b1);
    add(2'b10, 4, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 0, 32, 1'b1);
    add(2'b11, 1, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0,  7, 1'b0);
    add(2'b01, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0,  8, 1'b1);
    add(2'b00, 2, 8'h80, 8'h00, 8'h00, 8'h00, 4'b0010, 0, 0,  0, 1'b0);
    add(2'b00, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 4'b0010, 2, 0,  8, 1'b0);
    add(2'b01, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0,  0, 1'b0);
    add(2'b00, 2, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010, 0, 2, 16, 1'b1);
    add(2'b01, 4, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 4'b0000, 0, 0, 31, 1'b0);
    add(2'b00, 4, 8'h00, 8'h00, 8'h00, 8'h01, 4'b1000, 0, 0, 31, 1'b0);

    repeat (2) @(posedge clk);
    do_reset();

    foreach (frames[k]) run_frame(frames[k]);
    repeat (2) idle();

    // Abort an open frame with reset, then a fresh single-word frame.
    send(1'b1, 1'b0, 2'b00, 8'h00);
    send(1'b1, 1'b0, 2'b00, 8'h00);
    do_reset();
    begin
      frame_t f;
      f.m = 2'b00; f.n = 1; f.l = 4'b0001; f.pg = 0; f.ig = 0; f.ez = 2; f.ea = 1'b0;
      f.w = '0; f.w[0] = 8'h3F;
      run_frame(f);
    end

    repeat (4) idle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_frames got %0d outstanding want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
